// File: rtl/fp_search_ctrl.sv
// rtl/fp_search_ctrl.sv - fast-search sequencer: sweeps template vs test rows over vertical offsets
// Accumulates AND-popcount per offset and reports the best offset, its score and a threshold match.
module fp_search_ctrl #(
  parameter int ROWS      = 256,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 256,
  parameter int MAX_SHIFT = 8,
  parameter int OFF_W     = 5,
  parameter int SCORE_W   = 17
) (
  input  logic                     search_out_clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SCORE_W-1:0]       threshold,
  output logic [ADDR_W-1:0]        search_out_add,
  output logic [ADDR_W-1:0]        search_out_add_test,
  input  logic [2*DATA_W-1:0]      search_out_data,
  output logic                     busy,
  output logic                     done,
  output logic                     match,
  output logic [SCORE_W-1:0]       best_score,
  output logic signed [OFF_W-1:0]  best_offset
);

  localparam int PC_W = $clog2(DATA_W + 1);
  localparam logic signed [OFF_W-1:0]    OFF_MAX  = OFF_W'(MAX_SHIFT);
  localparam logic signed [OFF_W-1:0]    OFF_MIN  = -OFF_MAX;
  localparam logic [ADDR_W-1:0]          ROW_LAST = ADDR_W'(ROWS - 1);
  localparam logic signed [ADDR_W+1:0]   ROW_LIM  = (ADDR_W + 2)'(ROWS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        r_q, r_d;
  logic signed [OFF_W-1:0]  o_q, o_d;
  logic [SCORE_W-1:0]       thr_q, thr_d;
  logic [SCORE_W-1:0]       acc_q, acc_d;
  logic [SCORE_W-1:0]       best_score_q, best_score_d;
  logic signed [OFF_W-1:0]  best_off_q, best_off_d;
  logic                     match_q, match_d;
  logic                     stg_vld_q, stg_vld_d;
  logic                     stg_msk_q, stg_msk_d;
  logic                     stg_last_q, stg_last_d;
  logic signed [OFF_W-1:0]  stg_off_q, stg_off_d;

  logic signed [ADDR_W+1:0] tst_row;
  logic                     in_range;
  logic [PC_W-1:0]          pc;
  logic [SCORE_W-1:0]       contrib;
  logic [SCORE_W-1:0]       score;

  function automatic logic [PC_W-1:0] popcnt(input logic [DATA_W-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // Test row index is r+o, which may fall outside the template; those rows are masked.
  always_comb begin
    tst_row  = $signed({2'b00, r_q}) + $signed({{(ADDR_W + 2 - OFF_W){o_q[OFF_W-1]}}, o_q});
    in_range = !tst_row[ADDR_W+1] && (tst_row < ROW_LIM);
  end

  assign search_out_add      = (state_q == S_SCAN) ? r_q : '0;
  assign search_out_add_test = (state_q == S_SCAN && in_range) ? tst_row[ADDR_W-1:0] : '0;

  assign pc      = popcnt(search_out_data[2*DATA_W-1:DATA_W] & search_out_data[DATA_W-1:0]);
  assign contrib = (stg_vld_q && !stg_msk_q) ? SCORE_W'(pc) : '0;
  assign score   = acc_q + contrib;

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    o_d          = o_q;
    thr_d        = thr_q;
    acc_d        = acc_q;
    best_score_d = best_score_q;
    best_off_d   = best_off_q;
    match_d      = match_q;
    stg_vld_d    = 1'b0;
    stg_msk_d    = 1'b0;
    stg_last_d   = 1'b0;
    stg_off_d    = stg_off_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          thr_d        = threshold;
          r_d          = '0;
          o_d          = OFF_MIN;
          acc_d        = '0;
          best_score_d = '0;
          best_off_d   = OFF_MIN;
          match_d      = 1'b0;
          state_d      = S_SCAN;
        end
      end
      S_SCAN: begin
        stg_vld_d  = 1'b1;
        stg_msk_d  = !in_range;
        stg_last_d = (r_q == ROW_LAST);
        stg_off_d  = o_q;
        if (r_q == ROW_LAST) begin
          r_d = '0;
          if (o_q == OFF_MAX) begin
            state_d = S_DRAIN;
          end else begin
            o_d = o_q + OFF_W'(1);
          end
        end else begin
          r_d = r_q + ADDR_W'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Read stage retires one cycle behind its address; strict > keeps the earliest offset on ties.
    if (stg_vld_q) begin
      if (stg_last_q) begin
        acc_d = '0;
        if (score > best_score_q) begin
          best_score_d = score;
          best_off_d   = stg_off_q;
        end
      end else begin
        acc_d = score;
      end
    end

    // The final offset resolves while draining, so the decision is ready in the DONE cycle.
    if (state_q == S_DRAIN) begin
      match_d = (best_score_d >= thr_q);
    end
  end

  always_ff @(posedge search_out_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      r_q          <= '0;
      o_q          <= '0;
      thr_q        <= '0;
      acc_q        <= '0;
      best_score_q <= '0;
      best_off_q   <= '0;
      match_q      <= 1'b0;
      stg_vld_q    <= 1'b0;
      stg_msk_q    <= 1'b0;
      stg_last_q   <= 1'b0;
      stg_off_q    <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      o_q          <= o_d;
      thr_q        <= thr_d;
      acc_q        <= acc_d;
      best_score_q <= best_score_d;
      best_off_q   <= best_off_d;
      match_q      <= match_d;
      stg_vld_q    <= stg_vld_d;
      stg_msk_q    <= stg_msk_d;
      stg_last_q   <= stg_last_d;
      stg_off_q    <= stg_off_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign match       = match_q;
  assign best_score  = best_score_q;
  assign best_offset = best_off_q;

endmodule

// File: tb/tb_fp_search_ctrl.sv
// tb/tb_fp_search_ctrl.sv - directed self-checking bench for fp_search_ctrl
module tb_fp_search_ctrl;

  localparam int N = 4352;

  logic         clk;
  logic         rst;
  logic         start;
  logic [16:0]  threshold;
  logic [7:0]   search_out_add;
  logic [7:0]   search_out_add_test;
  logic [511:0] search_out_data;
  logic         busy;
  logic         done;
  logic         match;
  logic [16:0]  best_score;
  logic [4:0]   best_offset;

  logic [255:0] tmpl_mem [256];
  logic [255:0] test_mem [256];

  int n_tests;
  int n_fail;

  fp_search_ctrl dut (
    .search_out_clk      (clk),
    .rst                 (rst),
    .start               (start),
    .threshold           (threshold),
    .search_out_add      (search_out_add),
    .search_out_add_test (search_out_add_test),
    .search_out_data     (search_out_data),
    .busy                (busy),
    .done                (done),
    .match               (match),
    .best_score          (best_score),
    .best_offset         (best_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Store model: data for the address pair appears one cycle later.
  always @(posedge clk) begin
    search_out_data <= {tmpl_mem[search_out_add], test_mem[search_out_add_test]};
  end

  task automatic fill_ones();
    for (int k = 0; k < 256; k++) begin
      tmpl_mem[k] = '1;
      test_mem[k] = '1;
    end
  endtask

  task automatic fill_one_hot_shift();
    logic [255:0] v;
    for (int k = 0; k < 256; k++) begin
      v = 256'b1 << k;
      test_mem[k] = v;
      tmpl_mem[k] = (k + 3 < 256) ? (v << 3) : '0;
    end
  endtask

  // Runs one search; start is re-pulsed at cycles x1/x2 (0 = none).
  task automatic launch(input logic [16:0] thr, input int x1, input int x2,
                        output int done_at, output int done_n, output logic busy1,
                        output logic busy_end, output logic match_at_done);
    threshold = thr;
    start = 1'b1;
    @(posedge clk);
    done_at = -1;
    done_n = 0;
    busy1 = 1'b0;
    busy_end = 1'b1;
    match_at_done = 1'b0;
    for (int c = 1; c <= N + 8; c++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c;
          match_at_done = match;
        end
      end
      if (c == 1) busy1 = busy;
      if (c == N + 3) busy_end = busy;
      start = (c == x1 || c == x2);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({busy, done, match, best_score, best_offset, search_out_add, search_out_add_test} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b match=%b score=%0d off=%0d add=%0d addt=%0d required all 0",
               busy, done, match, best_score, best_offset, search_out_add, search_out_add_test);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, search_out_add, search_out_add_test} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b add=%0d required 0", busy, done, search_out_add);
    end
  endtask

  task automatic test_all_ones();
    int da, dn;
    logic b1, be, md;
    fill_ones();
    launch(17'd65536, 0, 0, da, dn, b1, be, md);
    n_tests++;
    if (da !== 4354 || dn !== 1) begin
      n_fail++;
      $display("FAIL ones_done_timing: got cycle %0d count %0d required cycle 4354 count 1", da, dn);
    end
    n_tests++;
    if (b1 !== 1'b1 || be !== 1'b0) begin
      n_fail++;
      $display("FAIL ones_busy: got busy@1=%b busy@N+3=%b required 1 0", b1, be);
    end
    n_tests++;
    if (best_score !== 17'd65536 || best_offset !== 5'd0 || md !== 1'b1 || match !== 1'b1) begin
      n_fail++;
      $display("FAIL ones_result: got score %0d off %0h match %b/%b required 65536 0 1", best_score, best_offset, md, match);
    end
  endtask

  task automatic test_zero_template();
    int da, dn;
    logic b1, be, md;
    for (int k = 0; k < 256; k++) begin
      tmpl_mem[k] = '0;
      test_mem[k] = '1;
    end
    launch(17'd1, 0, 0, da, dn, b1, be, md);
    n_tests++;
    if (best_score !== 17'd0 || best_offset !== 5'h18 || md !== 1'b0 || dn !== 1) begin
      n_fail++;
      $display("FAIL zero_thr1: got score %0d off %0h match %b done %0d required 0 18 0 1", best_score, best_offset, md, dn);
    end
    launch(17'd0, 0, 0, da, dn, b1, be, md);
    n_tests++;
    if (best_score !== 17'd0 || best_offset !== 5'h18 || md !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_thr0: got score %0d off %0h match %b required 0 18 1", best_score, best_offset, md);
    end
  endtask

  task automatic test_one_hot_shift();
    int da, dn;
    logic b1, be, md;
    fill_one_hot_shift();
    launch(17'd253, 0, 0, da, dn, b1, be, md);
    n_tests++;
    if (best_score !== 17'd253 || best_offset !== 5'h03 || md !== 1'b1 || da !== 4354) begin
      n_fail++;
      $display("FAIL shift3: got score %0d off %0h match %b done@%0d required 253 03 1 4354", best_score, best_offset, md, da);
    end
  endtask

  task automatic test_addr_sequence();
    int tbl_c [15] = '{1, 2, 8, 9, 10, 256, 257, 264, 265, 2200, 4344, 4345, 4352, 4353, 4354};
    int tbl_a [15] = '{0, 1, 7, 8, 9, 255, 0, 7, 8, 151, 247, 248, 255, 0, 0};
    int tbl_t [15] = '{0, 0, 0, 0, 1, 247, 0, 0, 1, 151, 255, 0, 0, 0, 0};
    int idx;
    threshold = 17'd0;
    start = 1'b1;
    @(posedge clk);
    idx = 0;
    for (int c = 1; c <= N + 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (idx < 15 && c == tbl_c[idx]) begin
        n_tests++;
        if (search_out_add !== 8'(tbl_a[idx]) || search_out_add_test !== 8'(tbl_t[idx])) begin
          n_fail++;
          $display("FAIL addr_c%0d: got add=%0d addt=%0d required add=%0d addt=%0d",
                   c, search_out_add, search_out_add_test, tbl_a[idx], tbl_t[idx]);
        end
        idx++;
      end
    end
  endtask

  task automatic test_start_ignored();
    int da, dn;
    logic b1, be, md;
    fill_one_hot_shift();
    launch(17'd254, 100, 4354, da, dn, b1, be, md);
    n_tests++;
    if (da !== 4354 || dn !== 1 || be !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: got done@%0d count %0d busy@N+3=%b required 4354 1 0", da, dn, be);
    end
    n_tests++;
    if (best_score !== 17'd253 || best_offset !== 5'h03 || md !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored_result: got score %0d off %0h match %b required 253 03 0", best_score, best_offset, md);
    end
  endtask

  task automatic test_reset_mid_scan();
    int da, dn;
    logic b1, be, md;
    fill_one_hot_shift();
    threshold = 17'd200;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c < 2000; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, match, best_score, best_offset, search_out_add, search_out_add_test} !== '0) begin
      n_fail++;
      $display("FAIL midscan_reset: got busy=%b done=%b match=%b score=%0d off=%0h add=%0d addt=%0d required all 0",
               busy, done, match, best_score, best_offset, search_out_add, search_out_add_test);
    end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    n_tests++;
    if (dn !== 0) begin
      n_fail++;
      $display("FAIL midscan_no_done: got %0d active cycles required 0", dn);
    end
    launch(17'd200, 0, 0, da, dn, b1, be, md);
    n_tests++;
    if (best_score !== 17'd253 || best_offset !== 5'h03 || md !== 1'b1 || da !== 4354 || dn !== 1) begin
      n_fail++;
      $display("FAIL after_reset_run: got score %0d off %0h match %b done@%0d x%0d required 253 03 1 4354 x1",
               best_score, best_offset, md, da, dn);
    end
  endtask

  task automatic test_ties();
    int da, dn;
    logic b1, be, md;
    logic [255:0] v;
    for (int k = 0; k < 256; k++) begin
      v = 256'b1 << k;
      test_mem[k] = v;
      tmpl_mem[k] = (k >= 2 ? (v >> 2) : '0) | (k + 2 < 256 ? (v << 2) : '0);
    end
    launch(17'd255, 0, 0, da, dn, b1, be, md);
    n_tests++;
    if (best_score !== 17'd254 || best_offset !== 5'h1E || md !== 1'b0) begin
      n_fail++;
      $display("FAIL ties: got score %0d off %0h match %b required 254 1e 0", best_score, best_offset, md);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    threshold = '0;
    for (int k = 0; k < 256; k++) begin
      tmpl_mem[k] = '0;
      test_mem[k] = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_all_ones();
    test_zero_template();
    test_one_hot_shift();
    test_addr_sequence();
    test_start_ignored();
    test_reset_mid_scan();
    test_ties();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_search_ctrl.md
# fp_search_ctrl

Sequencer for the fingerprint store's fast-search read port. It sweeps every stored-template row against the test-fingerprint row at a range of vertical offsets. For each offset it accumulates the bitwise-AND popcount of the two 256-bit rows, then reports the best offset, its score and a threshold match decision. It sits between the match-control logic and the search side of the fingerprint store, and drives both search address buses.

## Interface
Parameters:
- ROWS, 256, rows per template; addresses are 0..ROWS-1.
- ADDR_W, 8, address width; 2^ADDR_W >= ROWS.
- DATA_W, 256, bits per row per template.
- MAX_SHIFT, 8, offsets swept are -MAX_SHIFT..+MAX_SHIFT.
- OFF_W, 5, signed offset width; holds ±MAX_SHIFT.
- SCORE_W, 17, score width; holds ROWS*DATA_W.

Ports:
- search_out_clk  in  1  sole clock; search store read clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; honoured only in IDLE.
- threshold  in  SCORE_W  sampled on accepted start.
- search_out_add  out  ADDR_W  stored-template row address.
- search_out_add_test  out  ADDR_W  test-fingerprint row address.
- search_out_data  in  2*DATA_W  [2*DATA_W-1:DATA_W] is the template row; [DATA_W-1:0] is the test row. Both are valid one cycle after the address.
- busy  out  1  high from the accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- match  out  1  best_score >= sampled threshold.
- best_score  out  SCORE_W  highest per-offset score.
- best_offset  out  OFF_W  signed offset that produced best_score.

## Operation
- The state machine has four states: IDLE, SCAN, DRAIN and DONE.
- IDLE:
  - On start=1, capture threshold, set offset o=-MAX_SHIFT, row r=0, best_score=0, best_offset=-MAX_SHIFT, and enter SCAN.
  - start outside IDLE is ignored.
- SCAN: each cycle drives one address pair.
  - search_out_add = r.
  - search_out_add_test = r+o when 0 <= r+o < ROWS. Otherwise it is driven 0 and the row is flagged masked.
  - r increments each cycle. When r = ROWS-1, r wraps to 0 and o increments.
  - After the pair (ROWS-1, +MAX_SHIFT), go to DRAIN.
- Read pipeline:
  - A valid/masked/last-row flag travels one stage behind the address.
  - On a valid, unmasked stage, add popcount(tmpl & test) to acc. A masked row contributes 0.
  - On the last-row stage of each offset, form score = acc + this row's contribution.
  - If score > best_score, update best_score and best_offset. The comparison is strictly greater, so on a tie the earliest (most negative) offset is kept.
  - acc clears for the next offset.
- DRAIN: one cycle while the final stage retires; then go to DONE.
- DONE:
  - Assert done for one cycle.
  - Register match = (best_score >= threshold).
  - Return to IDLE.
- busy, best_score, best_offset and match hold their values until the next accepted start.
- When not in SCAN, both address outputs are 0.
- Widths:
  - popcount is ceil(log2(DATA_W+1)) bits, zero-extended to SCORE_W.
  - Scores never overflow: the maximum is ROWS*DATA_W.
  - best_offset is two's complement.

## Timing
- Reset values: every output is 0, state is IDLE, all internal counters are 0.
- Reset asserted mid-scan aborts immediately. No done is generated. Outputs return to reset values.
- Let N = (2*MAX_SHIFT+1)*ROWS, which is 4352 at the defaults.
- Cycle 0 is the cycle where start is sampled high in IDLE. Then:
  - Cycles 1..N are SCAN.
  - Cycle N+1 is DRAIN.
  - Cycle N+2 is DONE, with done=1 and match valid.
  - Cycle N+3 is back in IDLE, with busy=0.
- busy rises at cycle 1 and falls after cycle N+2.
- A start in the DONE cycle is ignored. A start in the following IDLE cycle is accepted.
- There are no gaps between offsets: the address streams continuously across the offset boundary.

## Test plan
- Store model returns all-ones for both rows; threshold=65536; start -> per-offset score (256-|o|)*256. Required: best_offset=0, best_score=65536, match=1, done at cycle 4354 only.
- Template rows all zero; threshold=1 -> best_score=0, best_offset=-8, match=0. Repeat with threshold=0 -> match=1.
- Test row k = one-hot(k mod 256); template row k = test row k+3 (zero outside range) -> best_offset=+3, best_score=253.
- Address check at offset -8, rows 0..7: search_out_add_test=0, masked, no contribution. Row 8: search_out_add_test=0, unmasked. Check the wrap at r=255 -> o increments and r=0 on the next cycle.
- Pulse start at cycles 100 and 4354 of a run -> both ignored, single done. Assert rst at cycle 2000 -> all outputs 0 and no done. A fresh start then completes with correct results.
- Ties: make offsets -2 and +2 score equal and maximal -> best_offset=-2.
